riscv_hpm_counters: RTL and testbench
=====================================

Name: riscv_hpm_counters

Overview:
- Parametrised hardware performance monitor (HPM) counter bank for the RV12 CSR unit. Privilege spec 1.11 style.
- Implements mcycle, minstret and HPM_CNT programmable mhpmcounter/mhpmevent pairs, plus mcountinhibit and mcounteren.
- Provides user-mode read-only shadows (CYCLE/INSTRET/HPMCOUNTERn) with permission checking.
- Sits beside the state/CSR block and is accessed over a registered CSR read/write port.

Parameters:
XLEN, 32, CSR data width; 32 or 64 only.
HPM_CNT, 4, number of programmable counters (0..29); they map to index 3..3+HPM_CNT-1.
EVENT_CNT, 8, number of event inputs (1..255).
CNT_W, 64, counter width for all counters (33..64).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
prv_i  in  2  current privilege level; 11=M, 01=S, 00=U
csr_re_i  in  1  CSR read request
csr_we_i  in  1  CSR write request
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  CSR write data (final value after CSRRW/RS/RC resolution)
csr_rdata_o  out  XLEN  read data, valid the cycle after csr_re_i
csr_illegal_o  out  1  access illegal, valid the cycle after csr_re_i/csr_we_i
instret_i  in  1  one instruction retired this cycle
event_i  in  EVENT_CNT  event strobes; bit k is event number k+1

Behaviour:
- Reset (async, rst_ni low):
  - All counters = 0, all mhpmevent = 0, mcountinhibit = 0, mcounteren = 0.
  - csr_rdata_o = 0, csr_illegal_o = 0.
- Increment rules, evaluated every cycle per counter:
  - mcycle: +1 when mcountinhibit[0] = 0.
  - minstret: +instret_i when mcountinhibit[2] = 0.
  - mhpmcounter_n: +1 when mhpmevent_n != 0, event_i[mhpmevent_n-1] = 1, and mcountinhibit[n] = 0.
  - mcountinhibit[1] (TM) is hardwired 0.
  - Counters wrap modulo 2^CNT_W with no flag.
- Write/increment collision: a CSR write to a counter (either half) takes effect next cycle. The increment in that cycle is discarded for the written half. In RV32, a low-half write still leaves the high half unchanged (no carry is applied).
- RV32 (XLEN = 32):
  - 'hB00/'hB02/'hB03+ write bits 31:0; 'hB80/'hB82/'hB83+ write bits CNT_W-1:32.
  - Bits of the high half at or above CNT_W read 0.
- RV64 (XLEN = 64):
  - Full-width access through the low-half addresses.
  - Any access to the *H addresses ('hB80-'hB9F, 'hC80-'hC9F) is illegal.
- mhpmevent ('h323+):
  - Width is $clog2(EVENT_CNT+1) bits; upper bits read 0.
  - A written value greater than EVENT_CNT is stored as 0 (WARL).
- mcountinhibit ('h320) and mcounteren ('h306):
  - Implemented bits are 0, 2 and 3..3+HPM_CNT-1; all other bits read 0.
- Unimplemented HPM indices (3+HPM_CNT..31) for 'hB03-'hB1F, 'hB83-'hB9F and 'h323-'h33F: read 0, writes ignored, not illegal.
- User shadows ('hC00-'hC1F, 'hC80-'hC9F):
  - 'hC01/'hC81 (time) is not served here and is illegal.
  - Any write to a shadow is illegal.
  - Read is illegal when prv_i != M and mcounteren[idx] = 0; otherwise it returns the matching counter.
- M-mode CSRs: access with prv_i != M is illegal.
- Addresses outside this block's range: csr_rdata_o = 0, csr_illegal_o = 0 (another block decodes them).
- Illegal write: no state is updated.
- Read latency is 1 cycle (registered):
  - Read-during-write to the same address returns the pre-write value.
  - When csr_re_i = 0 and csr_we_i = 0 next cycle, csr_rdata_o holds its last value and csr_illegal_o returns to 0.
- Reset asserted mid-count or mid-access: immediate return to reset values; no pending write survives.

Test Plan:
- Reset then 10 cycles idle, prv=M, read 'hB00 -> rdata=10 (±1 for read latency, fixed by the bench), illegal=0. Read 'hB02 with instret_i toggled 4 times -> 4.
- XLEN=32: write 'hB00=32'hFFFF_FFFE, 'hB80=0, wait 3 cycles -> 'hB80 reads 1, 'hB00 reads 1. Write 'hB00 on the same cycle as the increment -> the written value is observed exactly.
- HPM_CNT=4: write 'h323=3, pulse event_i[2] 5 times and event_i[0] 2 times -> 'hB03 reads 5. Write 'h323=EVENT_CNT+1 -> reads 0 and the counter stops.
- Write mcountinhibit=32'h5 -> mcycle and minstret frozen for 20 cycles; 'hB03 still counts. Read back -> 32'h5. Write 32'h2 -> reads 0.
- prv=U, mcounteren=0, read 'hC00 -> illegal=1. Set mcounteren[0]=1 -> read succeeds with the mcycle value. Write 'hC00 in M -> illegal=1. Read 'hB07 (unimplemented) -> 0, illegal=0.
- XLEN=64: read 'hB80 -> illegal=1. Assert rst_ni low mid-count -> all reads 0 after release.

Source files
------------

// File: rtl/riscv_hpm_counters.sv
// Machine-mode performance counter bank: mcycle, minstret, mhpmcounter/mhpmevent,
// mcountinhibit, mcounteren and the user read-only shadows, behind a registered CSR port.
module riscv_hpm_counters #(
    parameter int XLEN      = 32,
    parameter int HPM_CNT   = 4,
    parameter int EVENT_CNT = 8,
    parameter int CNT_W     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           prv_i,
    input  logic                 csr_re_i,
    input  logic                 csr_we_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [XLEN-1:0]      csr_wdata_i,
    output logic [XLEN-1:0]      csr_rdata_o,
    output logic                 csr_illegal_o,
    input  logic                 instret_i,
    input  logic [EVENT_CNT-1:0] event_i
);
    localparam int          NC      = HPM_CNT + 3;
    localparam int          EW      = $clog2(EVENT_CNT + 1);
    localparam logic [63:0] NC_MASK = (64'd1 << NC) - 64'd1;
    localparam logic [31:0] IMPL    = NC_MASK[31:0] & ~32'h2;

    typedef enum logic [2:0] {
        R_NONE, R_CNT_LO, R_CNT_HI, R_USR_LO, R_USR_HI, R_EVT, R_INH, R_EN
    } region_e;

    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [EW-1:0]      evt_q [32];
    logic [EW-1:0]      evt_d [32];
    logic [31:0]        inh_q, inh_d, en_q, en_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               illegal_q, illegal_d;

    region_e            region;
    logic [4:0]         idx;
    logic               is_m, ill, wr_ok;
    logic [63:0]        cnt64;
    logic [EVENT_CNT:0] ev_ext;

    // Event number 0 maps onto a constant-zero bit so "no event" never counts.
    assign ev_ext = {event_i, 1'b0};

    always_comb begin
        idx    = csr_addr_i[4:0];
        is_m   = (prv_i == 2'b11);
        region = R_NONE;
        case (csr_addr_i[11:5])
            7'h58:   region = (idx == 5'd1) ? R_NONE : R_CNT_LO;
            7'h5C:   region = (idx == 5'd1) ? R_NONE : R_CNT_HI;
            7'h60:   region = R_USR_LO;
            7'h64:   region = R_USR_HI;
            7'h19:   region = (idx == 5'd0) ? R_INH : ((idx >= 5'd3) ? R_EVT : R_NONE);
            default: if (csr_addr_i == 12'h306) region = R_EN;
        endcase

        ill = 1'b0;
        case (region)
            R_CNT_LO, R_EVT, R_INH, R_EN: ill = !is_m;
            R_CNT_HI:                     ill = !is_m || (XLEN == 64);
            R_USR_LO, R_USR_HI:           ill = csr_we_i || (idx == 5'd1) || (!is_m && !en_q[idx])
                                                || ((region == R_USR_HI) && (XLEN == 64));
            default:                      ill = 1'b0;
        endcase

        wr_ok     = csr_we_i && !ill;
        illegal_d = (csr_re_i || csr_we_i) && ill;

        cnt64   = 64'(cnt_q[idx]);
        rdata_d = '0;
        if (!ill) begin
            case (region)
                R_CNT_LO, R_USR_LO: rdata_d = cnt64[XLEN-1:0];
                R_CNT_HI, R_USR_HI: rdata_d = XLEN'(cnt64[63:32]);
                R_EVT:              rdata_d = XLEN'(evt_q[idx]);
                R_INH:              rdata_d = XLEN'(inh_q);
                R_EN:               rdata_d = XLEN'(en_q);
                default:            rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        logic             inc;
        logic [CNT_W-1:0] sum;
        inh_d = inh_q;
        en_d  = en_q;
        if (wr_ok && region == R_INH) inh_d = csr_wdata_i[31:0] & IMPL;
        if (wr_ok && region == R_EN)  en_d  = csr_wdata_i[31:0] & IMPL;

        for (int unsigned i = 0; i < 32; i++) begin
            case (i)
                0:       inc = !inh_q[0];
                2:       inc = instret_i && !inh_q[2];
                default: inc = (i >= 3) && ev_ext[evt_q[5'(i)]] && !inh_q[5'(i)];
            endcase
            inc            = inc && IMPL[5'(i)];
            sum            = cnt_q[5'(i)] + CNT_W'(inc);
            cnt_d[5'(i)]   = sum;
            evt_d[5'(i)]   = evt_q[5'(i)];
            // A written half takes the write data; the other half keeps counting but never carries.
            if (wr_ok && idx == 5'(i) && IMPL[5'(i)]) begin
                case (region)
                    R_CNT_LO: begin
                        if (XLEN == 32) cnt_d[5'(i)] = {cnt_q[5'(i)][CNT_W-1:32], csr_wdata_i[31:0]};
                        else            cnt_d[5'(i)] = CNT_W'(csr_wdata_i);
                    end
                    R_CNT_HI: cnt_d[5'(i)] = {(CNT_W-32)'(csr_wdata_i), sum[31:0]};
                    R_EVT:    evt_d[5'(i)] = (csr_wdata_i > XLEN'(EVENT_CNT)) ? '0 : EW'(csr_wdata_i);
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '{default: '0};
            evt_q     <= '{default: '0};
            inh_q     <= '0;
            en_q      <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
            inh_q     <= inh_d;
            en_q      <= en_d;
            illegal_q <= illegal_d;
            if (csr_re_i) rdata_q <= rdata_d;
        end
    end

    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = illegal_q;

endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Directed bench for riscv_hpm_counters: one RV32 and one RV64 instance with hand-computed expectations.
module tb_riscv_hpm_counters;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  prv;
    logic        instret;
    logic [7:0]  ev;
    logic        re, we, re64, we64;
    logic [11:0] addr, addr64;
    logic [31:0] wdata, rdata;
    logic [63:0] wdata64, rdata64;
    logic        ill, ill64;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    riscv_hpm_counters #(.XLEN(32), .HPM_CNT(4), .EVENT_CNT(8), .CNT_W(64)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .prv_i(prv), .csr_re_i(re), .csr_we_i(we),
        .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata), .csr_illegal_o(ill),
        .instret_i(instret), .event_i(ev)
    );

    riscv_hpm_counters #(.XLEN(64), .HPM_CNT(4), .EVENT_CNT(8), .CNT_W(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .prv_i(prv), .csr_re_i(re64), .csr_we_i(we64),
        .csr_addr_i(addr64), .csr_wdata_i(wdata64), .csr_rdata_o(rdata64), .csr_illegal_o(ill64),
        .instret_i(instret), .event_i(ev)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] ed, input logic ei);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        chk({tag, "_data"}, 64'(rdata), ed);
        chk({tag, "_ill"}, 64'(ill), 64'(ei));
    endtask

    task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] v, input logic ei);
        addr = a; wdata = v; we = 1'b1;
        tick();
        we = 1'b0;
        chk({tag, "_ill"}, 64'(ill), 64'(ei));
    endtask

    task automatic rd64_chk(input string tag, input logic [11:0] a, input logic [63:0] ed, input logic ei);
        addr64 = a; re64 = 1'b1;
        tick();
        re64 = 1'b0;
        chk({tag, "_data"}, rdata64, ed);
        chk({tag, "_ill"}, 64'(ill64), 64'(ei));
    endtask

    task automatic wr64_chk(input string tag, input logic [11:0] a, input logic [63:0] v, input logic ei);
        addr64 = a; wdata64 = v; we64 = 1'b1;
        tick();
        we64 = 1'b0;
        chk({tag, "_ill"}, 64'(ill64), 64'(ei));
    endtask

    initial begin
        rst_n = 1'b1; prv = 2'b11; instret = 1'b0; ev = '0;
        re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        re64 = 1'b0; we64 = 1'b0; addr64 = '0; wdata64 = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_ill", 64'(ill), 64'h0);
        chk("rst_rdata64", rdata64, 64'h0);
        tick(); tick();
        rst_n = 1'b1;

        repeat (10) tick();
        rd_chk("mcycle10", 12'hB00, 64'd10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            instret = 1'b1; tick();
            instret = 1'b0; tick();
        end
        rd_chk("minstret4", 12'hB02, 64'd4, 1'b0);

        // Low/high write then carry across the 32-bit boundary.
        wr_chk("wr_lo", 12'hB00, 32'hFFFF_FFFE, 1'b0);
        wr_chk("wr_hi", 12'hB80, 32'h0, 1'b0);
        tick();
        rd_chk("carry_hi", 12'hB80, 64'd1, 1'b0);
        rd_chk("carry_lo", 12'hB00, 64'd1, 1'b0);
        wr_chk("wr_coll", 12'hB00, 32'h1234_5678, 1'b0);
        rd_chk("coll_lo", 12'hB00, 64'h1234_5678, 1'b0);
        rd_chk("coll_hi", 12'hB80, 64'd1, 1'b0);
        addr = 12'hB80; wdata = 32'd5; re = 1'b1; we = 1'b1;
        tick();
        re = 1'b0; we = 1'b0;
        chk("rdw_old", 64'(rdata), 64'd1);
        rd_chk("rdw_new", 12'hB80, 64'd5, 1'b0);

        // Programmable counter 3 on event 3 (event_i[2]).
        wr_chk("evt_wr3", 12'h323, 32'd3, 1'b0);
        rd_chk("evt_rd3", 12'h323, 64'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            ev = 8'h04; tick();
            ev = 8'h00; tick();
        end
        for (int k = 0; k < 2; k++) begin
            ev = 8'h01; tick();
            ev = 8'h00; tick();
        end
        rd_chk("hpm3_5", 12'hB03, 64'd5, 1'b0);
        wr_chk("evt_wr9", 12'h323, 32'd9, 1'b0);
        rd_chk("evt_warl", 12'h323, 64'd0, 1'b0);
        ev = 8'hFF; repeat (3) tick(); ev = 8'h00;
        rd_chk("hpm3_stop", 12'hB03, 64'd5, 1'b0);
        wr_chk("evt_wr8", 12'h323, 32'd8, 1'b0);
        rd_chk("evt_max", 12'h323, 64'd8, 1'b0);
        wr_chk("evt_wr3b", 12'h323, 32'd3, 1'b0);

        // Inhibit mcycle/minstret while counter 3 keeps running.
        wr_chk("inh_wr5", 12'h320, 32'h5, 1'b0);
        wr_chk("mcyc_100", 12'hB00, 32'd100, 1'b0);
        ev = 8'h04; instret = 1'b1;
        repeat (20) tick();
        ev = 8'h00; instret = 1'b0;
        rd_chk("inh_mcyc", 12'hB00, 64'd100, 1'b0);
        rd_chk("inh_minst", 12'hB02, 64'd4, 1'b0);
        rd_chk("inh_hpm3", 12'hB03, 64'd25, 1'b0);
        rd_chk("inh_rd5", 12'h320, 64'h5, 1'b0);
        wr_chk("inh_wr2", 12'h320, 32'h2, 1'b0);
        rd_chk("inh_rd0", 12'h320, 64'h0, 1'b0);
        rd_chk("mcyc_resume", 12'hB00, 64'd101, 1'b0);

        // Privilege and shadow access.
        prv = 2'b00;
        rd_chk("u_cyc_deny", 12'hC00, 64'd0, 1'b1);
        prv = 2'b11;
        wr_chk("en_wr", 12'h306, 32'h1, 1'b0);
        rd_chk("en_rd", 12'h306, 64'h1, 1'b0);
        prv = 2'b00;
        rd_chk("u_cyc_ok", 12'hC00, 64'd105, 1'b0);
        rd_chk("u_inst_deny", 12'hC02, 64'd0, 1'b1);
        rd_chk("u_mcsr", 12'hB00, 64'd0, 1'b1);
        wr_chk("u_evt_wr", 12'h323, 32'd5, 1'b1);
        prv = 2'b11;
        wr_chk("unimpl_wr", 12'hB07, 32'd5, 1'b0);
        rd_chk("unimpl_rd", 12'hB07, 64'd0, 1'b0);
        rd_chk("time_ill", 12'hC01, 64'd0, 1'b1);
        rd_chk("foreign", 12'h300, 64'd0, 1'b0);
        rd_chk("evt_keep", 12'h323, 64'd3, 1'b0);
        wr_chk("shadow_wr", 12'hC00, 32'd7, 1'b1);
        chk("hold_after_wr", 64'(rdata), 64'd3);
        tick();
        chk("idle_rdata", 64'(rdata), 64'd3);
        chk("idle_ill", 64'(ill), 64'd0);

        // RV64 instance.
        wr64_chk("r64_wr", 12'hB00, 64'h1_0000_0005, 1'b0);
        rd64_chk("r64_hi", 12'hB80, 64'd0, 1'b1);
        wr64_chk("r64_wrhi", 12'hB83, 64'd1, 1'b1);
        rd64_chk("r64_uhi", 12'hC80, 64'd0, 1'b1);
        rd64_chk("r64_full", 12'hB00, 64'h1_0000_0008, 1'b0);

        // Asynchronous reset mid-count.
        rst_n = 1'b0;
        #1;
        chk("arst_rdata", 64'(rdata), 64'd0);
        chk("arst_rdata64", rdata64, 64'd0);
        tick();
        rst_n = 1'b1;
        rd_chk("post_mcyc", 12'hB00, 64'd0, 1'b0);
        rd_chk("post_minst", 12'hB02, 64'd0, 1'b0);
        rd_chk("post_evt", 12'h323, 64'd0, 1'b0);
        rd_chk("post_en", 12'h306, 64'd0, 1'b0);
        rd_chk("post_inh", 12'h320, 64'd0, 1'b0);
        rd64_chk("post64_mcyc", 12'hB00, 64'd5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
